// File: rtl/can_fd_crc_field_rx_pkg.sv
// Shared types and helpers for the CAN FD receive CRC-field extractor.
package can_fd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SBC  = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } can_fd_state_e;

    localparam int CAN_FD_SBC_W   = 4;
    localparam int CAN_FD_CRC17_W = 17;
    localparam int CAN_FD_CRC21_W = 21;

    function automatic logic [2:0] gray3_to_bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/can_fd_crc_field_rx_sbc_decode.sv
// Registered stuff-count decoder: loads Gray bits plus parity on a strobe,
// outputs the binary count and an even-parity error flag.
module can_fd_sbc_decode
    import can_fd_pkg::*;
#(
    parameter int SBC_W = CAN_FD_SBC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [SBC_W-1:0] i_bits,
    output logic [2:0]       o_cnt,
    output logic             o_parity_err
);

    logic [2:0] r_cnt;
    logic       r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 3'd0;
            r_parity_err <= 1'b0;
        end else if (i_clr) begin
            r_cnt        <= 3'd0;
            r_parity_err <= 1'b0;
        end else if (i_load) begin
            // Gray bits arrive first (MSB side); the last field bit is parity.
            r_cnt        <= gray3_to_bin(i_bits[SBC_W-1:SBC_W-3]);
            r_parity_err <= ^i_bits;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_parity_err = r_parity_err;

endmodule

// File: rtl/can_fd_crc_field_rx.sv
// CAN FD receive CRC-field destuffer/extractor: checks and drops fixed stuff
// bits, decodes the stuff count, captures CRC17/CRC21. Abort: CAN_FD_CRC_RX_ERR_ABORT_EN.
module can_fd_crc_field_rx
    import can_fd_pkg::*;
#(
    parameter int STUFF_PERIOD = 5,
    parameter int CRC_S_W      = CAN_FD_CRC17_W,
    parameter int CRC_L_W      = CAN_FD_CRC21_W,
    parameter int SBC_W        = CAN_FD_SBC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               crc21_sel,
    input  logic               last_bit_i,
    input  logic               enable,
    input  logic               data,
    output logic               busy,
    output logic               done,
    output logic [CRC_L_W-1:0] crc_o,
    output logic [2:0]         stuff_cnt_o,
    output logic               sbc_parity_err,
    output logic               fixed_stuff_err,
    output logic               fixed_stuff_err_sticky,
    output logic [1:0]         dbg_state
);

    localparam int PH_W  = $clog2(STUFF_PERIOD);
    localparam int CNT_W = $clog2(CRC_L_W + 1);

    can_fd_state_e      r_state;
    logic [PH_W-1:0]    r_phase;
    logic [CNT_W-1:0]   r_dcnt;
    logic               r_prev;
    logic               r_sel;
    logic [SBC_W-2:0]   r_sbc_sr;
    logic [CRC_L_W-1:0] r_crc;
    logic               r_busy;
    logic               r_done;
    logic               r_fse;
    logic               r_sticky;

    logic               w_active;
    logic               w_step;
    logic               w_stuff;
    logic               w_viol;
    logic               w_data_step;
    logic [CNT_W-1:0]   w_crc_last_idx;
    logic               w_sbc_last;
    logic               w_crc_last;
    logic [SBC_W-1:0]   w_sbc_bits;

    // start always wins over a coincident enable.
    assign w_active       = (r_state == SBC) || (r_state == CRC);
    assign w_step         = enable && w_active && !start;
    assign w_stuff        = (r_phase == '0);
    assign w_viol         = w_step && w_stuff && (data == r_prev);
    assign w_data_step    = w_step && !w_stuff;
    assign w_crc_last_idx = r_sel ? CNT_W'(CRC_L_W - 1) : CNT_W'(CRC_S_W - 1);
    assign w_sbc_last     = w_data_step && (r_state == SBC) && (r_dcnt == CNT_W'(SBC_W - 1));
    assign w_crc_last     = w_data_step && (r_state == CRC) && (r_dcnt == w_crc_last_idx);
    assign w_sbc_bits     = {r_sbc_sr, data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_dcnt   <= '0;
            r_prev   <= 1'b0;
            r_sel    <= 1'b0;
            r_sbc_sr <= '0;
            r_crc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fse    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_fse <= w_viol;
            if (start) begin
                r_state  <= SBC;
                r_phase  <= '0;
                r_dcnt   <= '0;
                r_prev   <= last_bit_i;
                r_sel    <= crc21_sel;
                r_sbc_sr <= '0;
                r_crc    <= '0;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
                r_sticky <= 1'b0;
            end else begin
                if (w_viol) begin
                    r_sticky <= 1'b1;
                end
                if (w_step) begin
                    r_prev  <= data;
                    r_phase <= (r_phase == PH_W'(STUFF_PERIOD - 1)) ? '0 : r_phase + 1'b1;
                end
                if (w_data_step) begin
                    if (r_state == SBC) begin
                        r_sbc_sr <= {r_sbc_sr[SBC_W-3:0], data};
                        if (w_sbc_last) begin
                            r_state <= CRC;
                            r_dcnt  <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end else begin
                        r_crc <= {r_crc[CRC_L_W-2:0], data};
                        if (w_crc_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                end
`ifdef CAN_FD_CRC_RX_ERR_ABORT_EN
                if (w_viol) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
`endif
                if (r_state == DONE) begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            end
        end
    end

    can_fd_sbc_decode #(
        .SBC_W (SBC_W)
    ) u_sbc_decode (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (start),
        .i_load       (w_sbc_last),
        .i_bits       (w_sbc_bits),
        .o_cnt        (stuff_cnt_o),
        .o_parity_err (sbc_parity_err)
    );

    assign busy                   = r_busy;
    assign done                   = r_done;
    assign crc_o                  = r_crc;
    assign fixed_stuff_err        = r_fse;
    assign fixed_stuff_err_sticky = r_sticky;
    assign dbg_state              = r_state;

endmodule

// File: tb/tb_can_fd_crc_field_rx.sv
// Directed bench for can_fd_crc_field_rx: frame vectors table plus restart,
// reset and idle-enable sequences.
module tb_can_fd_crc_field_rx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        crc21_sel;
    logic        last_bit_i;
    logic        enable;
    logic        data;
    logic        busy;
    logic        done;
    logic [20:0] crc_o;
    logic [2:0]  stuff_cnt_o;
    logic        sbc_parity_err;
    logic        fixed_stuff_err;
    logic        fixed_stuff_err_sticky;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    can_fd_crc_field_rx dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .crc21_sel              (crc21_sel),
        .last_bit_i             (last_bit_i),
        .enable                 (enable),
        .data                   (data),
        .busy                   (busy),
        .done                   (done),
        .crc_o                  (crc_o),
        .stuff_cnt_o            (stuff_cnt_o),
        .sbc_parity_err         (sbc_parity_err),
        .fixed_stuff_err        (fixed_stuff_err),
        .fixed_stuff_err_sticky (fixed_stuff_err_sticky),
        .dbg_state              (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        last;
        logic [3:0]  sbc;
        logic [20:0] crc;
        int          viol;
        int          gap;
        logic        se;
        logic [20:0] e_crc;
        logic [2:0]  e_cnt;
        logic        e_par;
        logic        e_sticky;
        int          e_fse;
        int          e_done_slot;
    } vec_t;

    vec_t vecs[8];
    logic strm[64];
    int   strm_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serialise SBC+CRC MSB-first with a stuff bit (inverse of predecessor) every 5 slots.
    task automatic build(input vec_t v);
        logic [24:0] d;
        int   nd, k, s;
        logic prev, b;
        nd   = v.sel ? 25 : 21;
        d    = v.sel ? {v.sbc, v.crc} : 25'({v.sbc, v.crc[16:0]});
        prev = v.last;
        k    = 0;
        s    = 0;
        while (k < nd) begin
            if (s % 5 == 0) begin
                b = (s == v.viol) ? prev : ~prev;
            end else begin
                b = d[nd-1-k];
                k++;
            end
            strm[s] = b;
            prev = b;
            s++;
        end
        strm_n = s;
    endtask

    task automatic pulse_start(input vec_t v);
        start      = 1'b1;
        crc21_sel  = v.sel;
        last_bit_i = v.last;
        enable     = v.se;
        data       = 1'($urandom_range(0, 1));
        tick();
        start  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int fse_cnt, done_cnt, done_slot, g;
        build(v);
        pulse_start(v);
        chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        fse_cnt = 0; done_cnt = 0; done_slot = -1;
        for (int i = 0; i < strm_n; i++) begin
            enable = 1'b1;
            data   = strm[i];
            tick();
            enable = 1'b0;
            if (fixed_stuff_err) fse_cnt++;
            if (done) begin
                done_cnt++;
                if (done_slot < 0) done_slot = i;
            end
            g = $urandom_range(0, v.gap);
            for (int j = 0; j < g; j++) begin
                tick();
                if (fixed_stuff_err) fse_cnt++;
                if (done) begin
                    done_cnt++;
                    if (done_slot < 0) done_slot = 1000 + i;
                end
            end
        end
        for (int j = 0; j < 2; j++) begin
            tick();
            if (fixed_stuff_err) fse_cnt++;
            if (done) begin
                done_cnt++;
                if (done_slot < 0) done_slot = 2000;
            end
        end
        chk({tag, ".done_cnt"}, 32'(done_cnt), (v.e_done_slot >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".done_slot"}, 32'(done_slot), 32'(v.e_done_slot));
        chk({tag, ".fse_pulses"}, 32'(fse_cnt), 32'(v.e_fse));
        chk({tag, ".crc_o"}, 32'(crc_o), 32'(v.e_crc));
        chk({tag, ".stuff_cnt"}, 32'(stuff_cnt_o), 32'(v.e_cnt));
        chk({tag, ".parity_err"}, 32'(sbc_parity_err), 32'(v.e_par));
        chk({tag, ".sticky"}, 32'(fixed_stuff_err_sticky), 32'(v.e_sticky));
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk({tag, ".state_end"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; crc21_sel = 1'b0; last_bit_i = 1'b0;
        enable = 1'b0; data = 1'b0;

        //          sel   last  sbc      crc         viol gap se    e_crc       cnt  par   stk   fse done
        vecs[0] = '{1'b0, 1'b1, 4'b0101, 21'h01A5A5, -1, 0, 1'b0, 21'h01A5A5, 3'd3, 1'b0, 1'b0, 0, 26};
        vecs[1] = '{1'b1, 1'b0, 4'b1001, 21'h155AA3, -1, 0, 1'b0, 21'h155AA3, 3'd7, 1'b0, 1'b0, 0, 31};
`ifdef CAN_FD_CRC_RX_ERR_ABORT_EN
        vecs[2] = '{1'b0, 1'b1, 4'b0101, 21'h01A5A5, 15, 0, 1'b0, 21'h0000D2, 3'd3, 1'b0, 1'b1, 1, -1};
`else
        vecs[2] = '{1'b0, 1'b1, 4'b0101, 21'h01A5A5, 15, 0, 1'b0, 21'h01A5A5, 3'd3, 1'b0, 1'b1, 1, 26};
`endif
        vecs[3] = '{1'b0, 1'b0, 4'b0100, 21'h01A5A5, -1, 0, 1'b0, 21'h01A5A5, 3'd3, 1'b1, 1'b0, 0, 26};
        vecs[4] = '{1'b0, 1'b1, 4'b0101, 21'h01A5A5, -1, 7, 1'b0, 21'h01A5A5, 3'd3, 1'b0, 1'b0, 0, 26};
        vecs[5] = '{1'b1, 1'b0, 4'b1001, 21'h155AA3, -1, 7, 1'b1, 21'h155AA3, 3'd7, 1'b0, 1'b0, 0, 31};
        vecs[6] = '{1'b0, 1'b0, 4'b0000, 21'h01FFFF, -1, 3, 1'b0, 21'h01FFFF, 3'd0, 1'b0, 1'b0, 0, 26};
        vecs[7] = '{1'b1, 1'b1, 4'b1111, 21'h1FFFFF, -1, 0, 1'b0, 21'h1FFFFF, 3'd5, 1'b0, 1'b0, 0, 31};

        repeat (3) tick();
        chk("reset.outputs", {busy, done, crc_o, stuff_cnt_o, sbc_parity_err,
                              fixed_stuff_err, fixed_stuff_err_sticky, dbg_state}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // Restart mid-frame: a frame with a stuff error is cut at slot 10 by a new start.
        begin
            vec_t vr;
            vr = vecs[0];
            vr.viol = 5;
            build(vr);
            pulse_start(vr);
            for (int i = 0; i < 10; i++) begin
                enable = 1'b1;
                data   = strm[i];
                tick();
                enable = 1'b0;
            end
            chk("restart.sticky_before", 32'(fixed_stuff_err_sticky), 32'd1);
            run_frame("restart", vecs[0]);
        end

        // Asynchronous reset in the middle of a 21-bit frame.
        build(vecs[1]);
        pulse_start(vecs[1]);
        for (int i = 0; i < 12; i++) begin
            enable = 1'b1;
            data   = strm[i];
            tick();
            enable = 1'b0;
        end
        chk("midreset.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.outputs", {busy, done, crc_o, stuff_cnt_o, sbc_parity_err,
                                 fixed_stuff_err, fixed_stuff_err_sticky, dbg_state}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Enables while idle must not wake the block.
        begin
            int act;
            act = 0;
            for (int i = 0; i < 8; i++) begin
                enable = 1'b1;
                data   = i[0];
                tick();
                if (busy || done || fixed_stuff_err || (crc_o != 21'd0) || (dbg_state != 2'd0)) act++;
            end
            enable = 1'b0;
            chk("idle.activity", 32'(act), 32'd0);
        end
        run_frame("post_idle", vecs[7]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
